// File: rtl/seq_tx.sv
// ============================================================================
//  Module   : seq_tx
//  Brief    : Serial frame transmitter (header 10100, payload MSB first,
//             trailer 00000). Optional macro SEQ_TX_STUFF_EN adds zero-run
//             stuffing inside the payload.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_tx #(
   parameter int DATA_W = 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic [DATA_W-1:0] data_in,
   output logic              s_out,
   output logic              busy,
   output logic              done
);

   localparam int                c_CW   = $clog2(DATA_W + 1);
   localparam logic [c_CW-1:0]   c_LAST = c_CW'(DATA_W - 1);
   localparam logic [7:0]        c_HDR  = 8'b0000_0101;  // bit i = header bit i

`ifdef SEQ_TX_STUFF_EN
   localparam logic [c_CW-1:0]   c_ALL  = c_CW'(DATA_W);

   typedef enum logic [4:0] {
      ST_IDLE    = 5'b00001,
      ST_HEADER  = 5'b00010,
      ST_PAYLOAD = 5'b00100,
      ST_TRAILER = 5'b01000,
      ST_STUFF   = 5'b10000
   } state_t;
`else
   typedef enum logic [3:0] {
      ST_IDLE    = 4'b0001,
      ST_HEADER  = 4'b0010,
      ST_PAYLOAD = 4'b0100,
      ST_TRAILER = 4'b1000
   } state_t;
`endif

   state_t            r_state, w_state_nxt;
   logic [2:0]        r_idx, w_idx_nxt;
   logic [DATA_W-1:0] r_shift, w_shift_nxt;
   logic [c_CW-1:0]   r_cnt, w_cnt_nxt;
   logic              w_sout_nxt, w_busy_nxt, w_done_nxt;
`ifdef SEQ_TX_STUFF_EN
   logic [2:0]        r_zrun, w_zrun_nxt;
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_shift_nxt = r_shift;
      w_cnt_nxt   = r_cnt;
      w_done_nxt  = 1'b0;
`ifdef SEQ_TX_STUFF_EN
      w_zrun_nxt  = r_zrun;
`endif
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_state_nxt = ST_HEADER;
               w_idx_nxt   = 3'd0;
               w_shift_nxt = data_in;
               w_cnt_nxt   = '0;
            end
         end
         ST_HEADER: begin
            if (r_idx == 3'd4) begin
               w_state_nxt = ST_PAYLOAD;
               w_idx_nxt   = 3'd0;
               w_cnt_nxt   = '0;
`ifdef SEQ_TX_STUFF_EN
               w_zrun_nxt  = 3'd0;
`endif
            end else begin
               w_idx_nxt = r_idx + 3'd1;
            end
         end
         ST_PAYLOAD: begin
            // The bit on the line this cycle is r_shift's MSB; consume it now.
            w_shift_nxt = r_shift << 1;
            w_cnt_nxt   = r_cnt + c_CW'(1);
`ifdef SEQ_TX_STUFF_EN
            w_zrun_nxt  = r_shift[DATA_W-1] ? 3'd0 : r_zrun + 3'd1;
            if (!r_shift[DATA_W-1] && (r_zrun == 3'd3)) begin
               w_state_nxt = ST_STUFF;
               w_zrun_nxt  = 3'd0;
            end else if (r_cnt == c_LAST) begin
               w_state_nxt = ST_TRAILER;
               w_idx_nxt   = 3'd0;
            end
`else
            if (r_cnt == c_LAST) begin
               w_state_nxt = ST_TRAILER;
               w_idx_nxt   = 3'd0;
            end
`endif
         end
`ifdef SEQ_TX_STUFF_EN
         ST_STUFF: begin
            w_idx_nxt   = 3'd0;
            w_state_nxt = (r_cnt == c_ALL) ? ST_TRAILER : ST_PAYLOAD;
         end
`endif
         ST_TRAILER: begin
            if (r_idx == 3'd4) begin
               w_state_nxt = ST_IDLE;
               w_idx_nxt   = 3'd0;
               w_done_nxt  = 1'b1;
            end else begin
               w_idx_nxt = r_idx + 3'd1;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_idx_nxt   = 3'd0;
            w_cnt_nxt   = '0;
         end
      endcase

      // Outputs are registered, so they are derived from the next state.
      w_busy_nxt = (w_state_nxt != ST_IDLE);
      case (w_state_nxt)
         ST_HEADER:  w_sout_nxt = c_HDR[w_idx_nxt];
         ST_PAYLOAD: w_sout_nxt = w_shift_nxt[DATA_W-1];
`ifdef SEQ_TX_STUFF_EN
         ST_STUFF:   w_sout_nxt = 1'b1;
`endif
         default:    w_sout_nxt = 1'b0;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_idx   <= 3'd0;
         r_shift <= '0;
         r_cnt   <= '0;
         s_out   <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
`ifdef SEQ_TX_STUFF_EN
         r_zrun  <= 3'd0;
`endif
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
         r_shift <= w_shift_nxt;
         r_cnt   <= w_cnt_nxt;
         s_out   <= w_sout_nxt;
         busy    <= w_busy_nxt;
         done    <= w_done_nxt;
`ifdef SEQ_TX_STUFF_EN
         r_zrun  <= w_zrun_nxt;
`endif
      end
   end

endmodule

`default_nettype wire
